// File: rtl/cdma_rr_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cdma_rr_scheduler
// Purpose  : Shares one DW-bit output channel among four per-user FIFOs using
//            round-robin arbitration with a bounded burst per user.
//            Each transfer pops the winning FIFO, registers its head word and
//            drives the crossbar routing code. A valid/ready handshake lets a
//            downstream stall back-pressure all FIFOs without loss or repeats.
// Ports    : clk        - clock, all state updates on rising edge
//            rst        - asynchronous active-low reset
//            req[3:0]   - FIFO i non-empty (bit 0 = user1)
//            fifo_data  - head word of each FIFO, user i at [i*DW +: DW]
//            pop[3:0]   - one-hot combinational dequeue strobe
//            out_valid  - data_out/sel hold a word for the crossbar
//            out_ready  - crossbar accepts the word this cycle
//            data_out   - registered output word
//            sel[1:0]   - registered source index of data_out
// Revision : 1.0 - initial release
// ============================================================================
module cdma_rr_scheduler #(
    parameter int DW    = 4,
    parameter int BURST = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      req,
    input  logic [4*DW-1:0] fifo_data,
    output logic [3:0]      pop,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   data_out,
    output logic [1:0]      sel
);

    localparam logic [3:0] C_BURST   = 4'(BURST);
    localparam logic [3:0] C_CNT_MAX = 4'hF;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t          state_q,     state_d;
    logic [1:0]      owner_q,     owner_d;
    logic            locked_q,    locked_d;
    logic [3:0]      burst_cnt_q, burst_cnt_d;
    logic            valid_q,     valid_d;
    logic [DW-1:0]   data_q,      data_d;
    logic [1:0]      sel_q,       sel_d;

    logic            w_free;
    logic            w_keep;
    logic            w_rr_found;
    logic [1:0]      w_rr_win;
    logic [1:0]      w_cand;
    logic [1:0]      w_win;
    logic [DW-1:0]   w_win_data;

    // Winner selection: a locked owner keeps the channel while it still
    // requests and has burst budget; otherwise scan from owner+1. The scan
    // includes the owner itself as its last candidate, so a lone requester
    // is always re-granted regardless of the burst limit.
    always_comb begin
        w_free     = !valid_q || out_ready;
        w_keep     = locked_q && req[owner_q] && (burst_cnt_q < C_BURST);
        w_rr_found = 1'b0;
        w_rr_win   = 2'd0;
        w_cand     = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            w_cand = owner_q + 2'(k);
            if (!w_rr_found && req[w_cand]) begin
                w_rr_found = 1'b1;
                w_rr_win   = w_cand;
            end
        end
        w_win      = w_keep ? owner_q : w_rr_win;
        w_win_data = '0;
        for (int i = 0; i < 4; i++) begin
            if (w_win == 2'(i)) begin
                w_win_data = fifo_data[i*DW +: DW];
            end
        end
    end

    // Next-state and pop strobe. A stalled slot (valid && !ready) leaves
    // every register at its current value and pops nothing.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        locked_d    = locked_q;
        burst_cnt_d = burst_cnt_q;
        valid_d     = valid_q;
        data_d      = data_q;
        sel_d       = sel_q;
        pop         = 4'b0000;

        if (w_free) begin
            if (|req) begin
                // pop is combinational, so it must be gated by the async
                // reset to stay low while the block is held in reset.
                pop         = rst ? (4'b0001 << w_win) : 4'b0000;
                data_d      = w_win_data;
                sel_d       = w_win;
                valid_d     = 1'b1;
                owner_d     = w_win;
                locked_d    = 1'b1;
                state_d     = S_SEND;
                if (w_win == owner_q && locked_q) begin
                    burst_cnt_d = (burst_cnt_q == C_CNT_MAX) ? C_CNT_MAX
                                                             : burst_cnt_q + 4'd1;
                end else begin
                    burst_cnt_d = 4'd1;
                end
            end else begin
                valid_d  = 1'b0;
                locked_d = 1'b0;
                state_d  = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            owner_q     <= 2'd3;
            locked_q    <= 1'b0;
            burst_cnt_q <= 4'd0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            sel_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            locked_q    <= locked_d;
            burst_cnt_q <= burst_cnt_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            sel_q       <= sel_d;
        end
    end

    assign out_valid = valid_q;
    assign data_out  = data_q;
    assign sel       = sel_q;

endmodule
`default_nettype wire

// File: tb/tb_cdma_rr_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_cdma_rr_scheduler
// Purpose  : Self-checking bench for cdma_rr_scheduler. Two instances
//            (BURST=2 and BURST=4) share one stimulus stream; a behavioural
//            model predicts both every cycle, and directed scenarios pin
//            hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdma_rr_scheduler;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic [3:0]  req       = 4'b0000;
    logic [15:0] fifo_data = 16'h0000;
    logic        out_ready = 1'b1;

    logic [3:0]  pop_a, pop_b;
    logic        ov_a, ov_b;
    logic [3:0]  do_a, do_b;
    logic [1:0]  sel_a, sel_b;

    always #5 clk = ~clk;

    cdma_rr_scheduler #(.DW(4), .BURST(2)) dut_a (
        .clk(clk), .rst(rst), .req(req), .fifo_data(fifo_data),
        .pop(pop_a), .out_valid(ov_a), .out_ready(out_ready),
        .data_out(do_a), .sel(sel_a)
    );

    cdma_rr_scheduler #(.DW(4), .BURST(4)) dut_b (
        .clk(clk), .rst(rst), .req(req), .fifo_data(fifo_data),
        .pop(pop_b), .out_valid(ov_b), .out_ready(out_ready),
        .data_out(do_b), .sel(sel_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model (index 0: BURST=2, 1: BURST=4) ----
    int m_burst  [2] = '{2, 4};
    int m_valid  [2] = '{0, 0};
    int m_data   [2] = '{0, 0};
    int m_sel    [2] = '{0, 0};
    int m_owner  [2] = '{3, 3};
    int m_locked [2] = '{0, 0};
    int m_cnt    [2] = '{0, 0};

    // Granted user for the current inputs, or -1 when nobody requests.
    function automatic int pick(input int k);
        if (m_locked[k] != 0 && req[m_owner[k]] && m_cnt[k] < m_burst[k])
            return m_owner[k];
        for (int off = 1; off <= 4; off++) begin
            int c;
            c = (m_owner[k] + off) % 4;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    function automatic int exp_pop(input int k);
        int w;
        if (!rst) return 0;
        if (m_valid[k] != 0 && !out_ready) return 0;
        w = pick(k);
        return (w < 0) ? 0 : (1 << w);
    endfunction

    always @(posedge clk or negedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                m_valid[k] = 0; m_data[k] = 0; m_sel[k] = 0;
                m_owner[k] = 3; m_locked[k] = 0; m_cnt[k] = 0;
            end else if (m_valid[k] == 0 || out_ready) begin
                int w;
                w = pick(k);
                if (w >= 0) begin
                    if (w == m_owner[k] && m_locked[k] != 0)
                        m_cnt[k] = (m_cnt[k] >= 15) ? 15 : m_cnt[k] + 1;
                    else
                        m_cnt[k] = 1;
                    m_data[k]   = int'((fifo_data >> (4 * w)) & 16'h000F);
                    m_sel[k]    = w;
                    m_valid[k]  = 1;
                    m_owner[k]  = w;
                    m_locked[k] = 1;
                end else begin
                    m_valid[k]  = 0;
                    m_locked[k] = 0;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("model_pop_b2",  int'(pop_a), exp_pop(0));
        check("model_pop_b4",  int'(pop_b), exp_pop(1));
        check("model_vld_b2",  int'(ov_a),  m_valid[0]);
        check("model_vld_b4",  int'(ov_b),  m_valid[1]);
        check("model_data_b2", int'(do_a),  m_data[0]);
        check("model_data_b4", int'(do_b),  m_data[1]);
        check("model_sel_b2",  int'(sel_a), m_sel[0]);
        check("model_sel_b4",  int'(sel_b), m_sel[1]);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int seq_a [10];
    int seq_b [10];
    int exp_a [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    int exp_b [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2};
    int drop_a [5] = '{1, 1, 3, 3, 1};
    int drop_b [5] = '{1, 1, 1, 1, 3};

    initial begin
        #1 rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;

        // All four requesting, ready held high: burst-limited rotation.
        req = 4'hF;
        for (int i = 0; i < 10; i++) begin
            fifo_data = 16'($urandom);
            tick();
            seq_a[i] = int'(sel_a);
            seq_b[i] = int'(sel_b);
            check("rr_no_bubble", int'(ov_a), 1);
        end
        for (int i = 0; i < 10; i++) begin
            check("rr_seq_burst2", seq_a[i], exp_a[i]);
            check("rr_seq_burst4", seq_b[i], exp_b[i]);
        end

        // Reset, then a single request from user3.
        req = 4'b0000;
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        req = 4'b0100;
        fifo_data = 16'h0A00;
        #1;
        check("single_pop", int'(pop_a), 4'b0100);
        tick();
        check("single_valid", int'(ov_a), 1);
        check("single_data",  int'(do_a), 4'hA);
        check("single_sel",   int'(sel_a), 2);
        req = 4'b0000;
        tick();
        check("single_drain", int'(ov_a), 0);

        // Stall: user2 word 5 held for three cycles, then accept + reload.
        req = 4'b0010;
        fifo_data = 16'h0050;
        tick();
        check("stall_load_data", int'(do_a), 4'h5);
        out_ready = 1'b0;
        req = 4'hF;
        fifo_data = 16'h4361;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_pop", int'(pop_a), 0);
            tick();
            check("stall_data", int'(do_a), 4'h5);
            check("stall_sel",  int'(sel_a), 1);
        end
        out_ready = 1'b1;
        #1;
        check("stall_release_pop", int'(pop_a), 4'b0010);
        tick();
        check("stall_reload_data", int'(do_a), 4'h6);
        check("stall_reload_vld",  int'(ov_a), 1);

        // Owner drop: user1 granted once, then it stops requesting.
        req = 4'b0000;
        tick();
        req = 4'b0001;
        fifo_data = 16'($urandom);
        tick();
        check("drop_first_sel", int'(sel_b), 0);
        req = 4'b1010;
        for (int i = 0; i < 5; i++) begin
            fifo_data = 16'($urandom);
            tick();
            check("drop_seq_burst2", int'(sel_a), drop_a[i]);
            check("drop_seq_burst4", int'(sel_b), drop_b[i]);
        end

        // Drain after granting user4, then wrap to user1.
        req = 4'b0000;
        tick();
        req = 4'b1000;
        tick();
        check("wrap_sel_u4", int'(sel_a), 3);
        req = 4'b0000;
        tick();
        check("wrap_drain_vld", int'(ov_a), 0);
        check("wrap_drain_sel", int'(sel_a), 3);
        req = 4'b1001;
        #1;
        check("wrap_pop", int'(pop_a), 4'b0001);
        tick();
        check("wrap_sel", int'(sel_a), 0);

        // Asynchronous reset in the middle of a stall.
        req = 4'b0100;
        fifo_data = 16'h0700;
        tick();
        out_ready = 1'b0;
        tick();
        check("pre_reset_vld", int'(ov_a), 1);
        #3;
        rst = 1'b0;
        #1;
        check("areset_vld_b2", int'(ov_a), 0);
        check("areset_vld_b4", int'(ov_b), 0);
        check("areset_pop_b2", int'(pop_a), 0);
        check("areset_pop_b4", int'(pop_b), 0);
        req = 4'b1100;
        out_ready = 1'b1;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("post_reset_pop", int'(pop_a), 4'b0100);
        tick();
        check("post_reset_sel_b2", int'(sel_a), 2);
        check("post_reset_sel_b4", int'(sel_b), 2);
        check("post_reset_vld",    int'(ov_a), 1);

        req = 4'b0000;
        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
